cordic_iter_ctrl: RTL and testbench

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

---
 rtl/cordic_iter_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// Folded (iterative) CORDIC controller: a single shared add/shift stage is
// reused once per clock for ITERATIONS micro-rotations.
//
// Ports
//   clk, nreset                 clock (rising edge), async active-low reset
//   start_valid / start_ready   operand handshake; start_ready high in IDLE
//   mode                        0 = rotation, 1 = vectoring (sampled at accept)
//   x_in, y_in, z_in            signed operands
//   abort                       synchronous cancel while ITER or DONE
//   busy                        high while micro-rotations are running
//   iter_idx                    current micro-rotation index
//   done_valid / done_ready     result handshake; results held until taken
//   x_out, y_out, z_out         registered results (no gain compensation)
//
// Optional feature: define CORDIC_ITER_CTRL_QUAD_EN to enable quadrant
// pre-correction of the operands at accept (full-circle convergence).
module cordic_iter_ctrl #(
  parameter int unsigned CORDIC_WIDTH = 22,
  parameter int unsigned ANGLE_WIDTH  = 22,
  parameter int unsigned ITERATIONS   = 16
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic                                mode,
  input  logic signed [CORDIC_WIDTH-1:0]      x_in,
  input  logic signed [CORDIC_WIDTH-1:0]      y_in,
  input  logic signed [ANGLE_WIDTH-1:0]       z_in,
  input  logic                                abort,
  output logic                                busy,
  output logic [$clog2(ITERATIONS+1)-1:0]     iter_idx,
  output logic                                done_valid,
  input  logic                                done_ready,
  output logic signed [CORDIC_WIDTH-1:0]      x_out,
  output logic signed [CORDIC_WIDTH-1:0]      y_out,
  output logic signed [ANGLE_WIDTH-1:0]       z_out
);

  localparam int unsigned IW = $clog2(ITERATIONS + 1);
  // Working width of the elaboration-time arctangent computation.
  localparam int unsigned TW = 256;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef CORDIC_ITER_CTRL_QUAD_EN
  localparam logic signed [ANGLE_WIDTH-1:0] HALF_PI = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};
  localparam logic signed [ANGLE_WIDTH-1:0] PI_ANG  = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
`endif

  // round(atan(2^-i)/pi * 2^(ANGLE_WIDTH-1)), evaluated at elaboration with
  // 2^-96 fixed point Taylor series; index 0 uses pi/4 directly.
  function automatic logic [ANGLE_WIDTH-1:0] atan_entry(input int unsigned i);
    logic [TW-1:0] pi_s;
    logic [TW-1:0] sum;
    logic [TW-1:0] term;
    logic [TW-1:0] num;
    int unsigned   n;
    pi_s = TW'(100'h3_243F6A88_85A308D3_13198A2E);
    sum  = '0;
    term = '0;
    if (i == 0) begin
      sum = pi_s >> 2;
    end else begin
      for (int unsigned k = 0; k < 64; k++) begin
        n = 2 * k + 1;
        if (i * n <= 96) begin
          term = (TW'(1) << (96 - i * n)) / TW'(n);
          if (k % 2 == 1) sum = sum - term;
          else            sum = sum + term;
        end
      end
    end
    num = (sum << (ANGLE_WIDTH - 1)) + (pi_s >> 1);
    return ANGLE_WIDTH'(num / pi_s);
  endfunction

  // One extra entry so the table index width equals the iter_idx width.
  logic signed [ANGLE_WIDTH-1:0] atan_tab [ITERATIONS+1];

  for (genvar g = 0; g <= ITERATIONS; g++) begin : g_atan
    localparam logic [ANGLE_WIDTH-1:0] ATAN_G = atan_entry(g);
    assign atan_tab[g] = ATAN_G;
  end

  logic [1:0]                     state, state_n;
  logic                           mode_r, mode_n;
  logic [IW-1:0]                  idx_n;
  logic signed [CORDIC_WIDTH-1:0] x_r, y_r, x_n, y_n;
  logic signed [ANGLE_WIDTH-1:0]  z_r, z_n;
  logic signed [CORDIC_WIDTH-1:0] xo_n, yo_n;
  logic signed [ANGLE_WIDTH-1:0]  zo_n;
  logic signed [CORDIC_WIDTH-1:0] x_ld, y_ld;
  logic signed [ANGLE_WIDTH-1:0]  z_ld;
  logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh;
  logic                           dir;

  // Operand load values (optionally mirrored into the right half-plane).
  always_comb begin
    x_ld = x_in;
    y_ld = y_in;
    z_ld = z_in;
`ifdef CORDIC_ITER_CTRL_QUAD_EN
    // Adding pi equals subtracting pi modulo 2^ANGLE_WIDTH, so one adder serves both modes.
    if (mode ? x_in[CORDIC_WIDTH-1] : ((z_in > HALF_PI) || (z_in < -HALF_PI))) begin
      x_ld = -x_in;
      y_ld = -y_in;
      z_ld = z_in + PI_ANG;
    end
`endif
  end

  // Shared micro-rotation stage.
  always_comb begin
    x_sh = x_r >>> iter_idx;
    y_sh = y_r >>> iter_idx;
    dir  = mode_r ? y_r[CORDIC_WIDTH-1] : ~z_r[ANGLE_WIDTH-1];
  end

  // Next-state and next-register values.
  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    idx_n   = iter_idx;
    x_n     = x_r;
    y_n     = y_r;
    z_n     = z_r;
    xo_n    = x_out;
    yo_n    = y_out;
    zo_n    = z_out;
    case (state)
      S_IDLE: begin
        if (start_valid && start_ready) begin
          state_n = S_ITER;
          mode_n  = mode;
          idx_n   = '0;
          x_n     = x_ld;
          y_n     = y_ld;
          z_n     = z_ld;
        end
      end
      S_ITER: begin
        if (abort) begin
          state_n = S_IDLE;
          idx_n   = '0;
          x_n     = '0;
          y_n     = '0;
          z_n     = '0;
          xo_n    = '0;
          yo_n    = '0;
          zo_n    = '0;
        end else if (iter_idx == IW'(ITERATIONS)) begin
          // All micro-rotations done: publish results on the following edge.
          state_n = S_DONE;
          xo_n    = x_r;
          yo_n    = y_r;
          zo_n    = z_r;
        end else begin
          idx_n = iter_idx + IW'(1);
          if (dir) begin
            x_n = x_r - y_sh;
            y_n = y_r + x_sh;
            z_n = z_r - atan_tab[iter_idx];
          end else begin
            x_n = x_r + y_sh;
            y_n = y_r - x_sh;
            z_n = z_r + atan_tab[iter_idx];
          end
        end
      end
      S_DONE: begin
        // Abort wins over a simultaneous result handshake.
        if (abort) begin
          state_n = S_IDLE;
          idx_n   = '0;
          x_n     = '0;
          y_n     = '0;
          z_n     = '0;
          xo_n    = '0;
          yo_n    = '0;
          zo_n    = '0;
        end else if (done_ready) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      mode_r      <= 1'b0;
      iter_idx    <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      x_out       <= '0;
      y_out       <= '0;
      z_out       <= '0;
      start_ready <= 1'b0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      mode_r      <= mode_n;
      iter_idx    <= idx_n;
      x_r         <= x_n;
      y_r         <= y_n;
      z_r         <= z_n;
      x_out       <= xo_n;
      y_out       <= yo_n;
      z_out       <= zo_n;
      start_ready <= (state_n == S_IDLE);
      busy        <= (state_n == S_ITER);
      done_valid  <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: directed vector table with
// tolerance checks, bit-exact comparison against a plain-arithmetic CORDIC
// model, handshake/abort/reset sequences, and randomized operations.
module tb_cordic_iter_ctrl;

  localparam int unsigned CW   = 22;
  localparam int unsigned AW   = 22;
  localparam int unsigned NIT  = 16;
  localparam int          LAT  = NIT + 1;
  localparam real         PI_R = 3.14159265358979323846;

  logic                 clk;
  logic                 nreset;
  logic                 start_valid;
  logic                 start_ready;
  logic                 mode;
  logic signed [CW-1:0] x_in, y_in;
  logic signed [AW-1:0] z_in;
  logic                 abort;
  logic                 busy;
  logic [4:0]           iter_idx;
  logic                 done_valid;
  logic                 done_ready;
  logic signed [CW-1:0] x_out, y_out;
  logic signed [AW-1:0] z_out;

  int n_cmp = 0;
  int n_err = 0;

  cordic_iter_ctrl #(.CORDIC_WIDTH(CW), .ANGLE_WIDTH(AW), .ITERATIONS(NIT)) dut (
    .clk(clk), .nreset(nreset), .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in), .abort(abort), .busy(busy),
    .iter_idx(iter_idx), .done_valid(done_valid), .done_ready(done_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     mode;
    longint x, y, z;
    longint ex, ey, ez;
    longint tx, ty, tz;
    bit     use_tol;
  } vec_t;

  function automatic longint wrap_c(input longint v);
    logic signed [CW-1:0] t;
    t = v[CW-1:0];
    return longint'(t);
  endfunction

  function automatic longint wrap_a(input longint v);
    logic signed [AW-1:0] t;
    t = v[AW-1:0];
    return longint'(t);
  endfunction

  // Reference CORDIC straight from the algorithm description.
  function automatic void model(input bit m, input longint xi, input longint yi, input longint zi,
                                output longint xo, output longint yo, output longint zo);
    longint x, y, z, xs, ys, at;
    bit d;
    x = wrap_c(xi);
    y = wrap_c(yi);
    z = wrap_a(zi);
`ifdef CORDIC_ITER_CTRL_QUAD_EN
    if (m ? (x < 0) : (z > (64'sd1 <<< (AW-2)) || z < -(64'sd1 <<< (AW-2)))) begin
      x = wrap_c(-x);
      y = wrap_c(-y);
      z = wrap_a(z + (64'sd1 <<< (AW-1)));
    end
`endif
    for (int i = 0; i < int'(NIT); i++) begin
      at = longint'($rtoi($atan(1.0 / (2.0 ** i)) / PI_R * (2.0 ** (AW-1)) + 0.5));
      d  = m ? (y < 0) : (z >= 0);
      xs = x >>> i;
      ys = y >>> i;
      if (d) begin
        x = wrap_c(x - ys); y = wrap_c(y + xs); z = wrap_a(z - at);
      end else begin
        x = wrap_c(x + ys); y = wrap_c(y - xs); z = wrap_a(z + at);
      end
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint exp,
                         input longint tol, input bit is_angle);
    longint d;
    d = is_angle ? wrap_a(act - exp) : (act - exp);
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, wait for done (bounded), hold, then take results.
  task automatic run_op(input bit m, input longint xi, input longint yi, input longint zi,
                        input int hold, output longint xo, output longint yo,
                        output longint zo, output int lat);
    int g;
    g = 0;
    while (!start_ready && g < 50) begin tick(); g++; end
    chk("start_ready_before_op", longint'(start_ready), 1);
    mode = m; x_in = CW'(xi); y_in = CW'(yi); z_in = AW'(zi);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 40) begin tick(); lat++; end
    repeat (hold) tick();
    xo = longint'(x_out); yo = longint'(y_out); zo = longint'(z_out);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    int g;
    g = 0;
    while (int'(iter_idx) != k && g < 40) begin tick(); g++; end
    chk($sformatf("reach_iter_idx_%0d", k), longint'(iter_idx), longint'(k));
  endtask

  vec_t   tv [7];
  longint ax, ay, az, mx, my, mz;
  longint sx, sy, sz;
  int     lat, cnt;

  initial begin
    tv[0] = '{1'b1,  100000,  100000,       0, 232893,       0,   524288, 32, 16, 64, 1'b1};
    tv[1] = '{1'b0,  100000,       0,  524288, 116447,  116447,        0, 32, 32, 64, 1'b1};
    tv[2] = '{1'b0,  100000,       0,       0, 164680,       0,        0, 32, 32, 64, 1'b1};
    tv[3] = '{1'b0,       0,  100000, -524288, 116447,  116447,        0, 32, 32, 64, 1'b1};
    tv[4] = '{1'b0,  100000,       0,-1048576,      0, -164680,        0, 32, 32, 64, 1'b1};
    tv[5] = '{1'b1,   50000,  -50000,       0, 116447,       0,  -524288, 32, 16, 64, 1'b1};
`ifdef CORDIC_ITER_CTRL_QUAD_EN
    tv[6] = '{1'b1, -100000,       0,       0, 164680,       0, -2097152, 32, 16, 64, 1'b1};
`else
    // Outside the convergence range without pre-correction: bit-exact model check only.
    tv[6] = '{1'b1, -100000,       0,       0, 164680,       0, -2097152, 32, 16, 64, 1'b0};
`endif

    nreset = 1'b0; start_valid = 1'b0; mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    abort = 1'b0; done_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done_valid", longint'(done_valid), 0);
    chk("rst_iter_idx", longint'(iter_idx), 0);
    chk("rst_start_ready", longint'(start_ready), 0);
    chk("rst_x_out", longint'(x_out), 0);
    chk("rst_z_out", longint'(z_out), 0);
    nreset = 1'b1;
    tick();
    chk("start_ready_after_rst", longint'(start_ready), 1);

    // Directed table.
    foreach (tv[k]) begin
      run_op(tv[k].mode, tv[k].x, tv[k].y, tv[k].z, 0, ax, ay, az, lat);
      model(tv[k].mode, tv[k].x, tv[k].y, tv[k].z, mx, my, mz);
      chk($sformatf("vec%0d_latency", k), longint'(lat), longint'(LAT));
      chk($sformatf("vec%0d_x_model", k), ax, mx);
      chk($sformatf("vec%0d_y_model", k), ay, my);
      chk($sformatf("vec%0d_z_model", k), az, mz);
      if (tv[k].use_tol) begin
        chk_tol($sformatf("vec%0d_x", k), ax, tv[k].ex, tv[k].tx, 1'b0);
        chk_tol($sformatf("vec%0d_y", k), ay, tv[k].ey, tv[k].ty, 1'b0);
        chk_tol($sformatf("vec%0d_z", k), az, tv[k].ez, tv[k].tz, 1'b1);
      end
    end

    // Result held while done_ready is low; a start during the handshake waits a cycle.
    mode = 1'b1; x_in = CW'(100000); y_in = CW'(100000); z_in = '0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_idx(5);
    lat = 0;
    while (!done_valid && lat < 40) begin tick(); lat++; end
    chk("hold_done_seen", longint'(done_valid), 1);
    sx = longint'(x_out); sy = longint'(y_out); sz = longint'(z_out);
    start_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold%0d_done_valid", c), longint'(done_valid), 1);
      chk($sformatf("hold%0d_start_ready", c), longint'(start_ready), 0);
      chk($sformatf("hold%0d_x", c), longint'(x_out), sx);
      chk($sformatf("hold%0d_y", c), longint'(y_out), sy);
      chk($sformatf("hold%0d_z", c), longint'(z_out), sz);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("handshake_done_valid", longint'(done_valid), 0);
    chk("handshake_start_ready", longint'(start_ready), 1);
    chk("handshake_not_accepted", longint'(busy), 0);
    tick();
    start_valid = 1'b0;
    chk("accepted_next_cycle", longint'(busy), 1);

    // Abort mid-iteration, then a clean operation.
    wait_idx(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done_valid", longint'(done_valid), 0);
    chk("abort_start_ready", longint'(start_ready), 1);
    chk("abort_iter_idx", longint'(iter_idx), 0);
    cnt = 0;
    repeat (25) begin tick(); if (done_valid) cnt++; end
    chk("abort_no_done", longint'(cnt), 0);
    run_op(1'b0, 100000, 0, 524288, 1, ax, ay, az, lat);
    model(1'b0, 100000, 0, 524288, mx, my, mz);
    chk("post_abort_latency", longint'(lat), longint'(LAT));
    chk("post_abort_x", ax, mx);
    chk("post_abort_y", ay, my);

    // Abort ignored in IDLE; abort in DONE clears the results.
    abort = 1'b1; start_valid = 1'b1; mode = 1'b0; x_in = CW'(70000); y_in = CW'(-3000);
    z_in = AW'(300000);
    tick();
    abort = 1'b0; start_valid = 1'b0;
    chk("idle_abort_ignored", longint'(busy), 1);
    lat = 0;
    while (!done_valid && lat < 40) begin tick(); lat++; end
    chk("done_before_abort", longint'(done_valid), 1);
    abort = 1'b1; done_ready = 1'b1;
    tick();
    abort = 1'b0; done_ready = 1'b0;
    chk("done_abort_valid", longint'(done_valid), 0);
    chk("done_abort_x", longint'(x_out), 0);
    chk("done_abort_y", longint'(y_out), 0);
    chk("done_abort_z", longint'(z_out), 0);

    // Reset mid-operation.
    mode = 1'b1; x_in = CW'(100000); y_in = CW'(100000); z_in = '0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_idx(3);
    nreset = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_iter_idx", longint'(iter_idx), 0);
    chk("midrst_done_valid", longint'(done_valid), 0);
    chk("midrst_x_out", longint'(x_out), 0);
    chk("midrst_y_out", longint'(y_out), 0);
    chk("midrst_z_out", longint'(z_out), 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    cnt = 0;
    repeat (25) begin tick(); if (done_valid) cnt++; end
    chk("midrst_no_done", longint'(cnt), 0);
    chk("midrst_start_ready", longint'(start_ready), 1);

    // Randomized operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      bit     rm;
      longint rx, ry, rz;
      rm = 1'($urandom_range(0, 1));
      rx = longint'($urandom_range(0, 1048575)) - 524288;
      ry = longint'($urandom_range(0, 1048575)) - 524288;
      rz = wrap_a(longint'($urandom));
      run_op(rm, rx, ry, rz, int'($urandom_range(0, 3)), ax, ay, az, lat);
      model(rm, rx, ry, rz, mx, my, mz);
      chk($sformatf("rnd%0d_latency", r), longint'(lat), longint'(LAT));
      chk($sformatf("rnd%0d_x", r), ax, mx);
      chk($sformatf("rnd%0d_y", r), ay, my);
      chk($sformatf("rnd%0d_z", r), az, mz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
